// File: rtl/tri_bus_arbiter_if.sv
// Request/grant, read-back and status signals shared between tri_bus_arbiter and its clients.
// The tri-state net itself stays a plain inout on the arbiter so it resolves as an ordinary wire.
interface tri_bus_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int N_CHANNEL = 4
);
    logic [N_CHANNEL-1:0]       i_req;
    logic [N_CHANNEL*WIDTH-1:0] i_data;
    logic [N_CHANNEL-1:0]       o_gnt;
    logic                       i_extReq;
    logic                       o_extGnt;
    logic                       o_oe;
    logic [WIDTH-1:0]           o_rdData;
    logic                       o_rdValid;
    logic                       o_contention;
    logic                       i_clrContention;

    // Client side: requesters and the external driver.
    modport master (
        output i_req,
        output i_data,
        output i_extReq,
        output i_clrContention,
        input  o_gnt,
        input  o_extGnt,
        input  o_oe,
        input  o_rdData,
        input  o_rdValid,
        input  o_contention
    );

    // Arbiter side.
    modport slave (
        input  i_req,
        input  i_data,
        input  i_extReq,
        input  i_clrContention,
        output o_gnt,
        output o_extGnt,
        output o_oe,
        output o_rdData,
        output o_rdValid,
        output o_contention
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus with turnaround gaps and external hand-off.
// Optional drive/readback compare enabled by TRI_BUS_ARBITER_CONTENTION_CHECK_EN.
//
// state | meaning
// IDLE  | bus free, arbitrate every cycle
// DRIVE | internal owner enabled onto b_bus
// TURN  | bus undriven; arbitration resumes in the last turnaround cycle
// EXT   | bus released to the external driver
module tri_bus_arbiter #(
    parameter int WIDTH       = 8,
    parameter int N_CHANNEL   = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_BURST   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    tri_bus_arbiter_if.slave        bus,
    inout  tri   [WIDTH-1:0]        b_bus
);
    localparam int IW = $clog2(N_CHANNEL);
    localparam int TW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);
    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [TW-1:0] TURN_INIT = TW'(TURN_CYCLES);
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

    if (TURN_CYCLES < 1) begin : gTurnCheck
        $error("tri_bus_arbiter: TURN_CYCLES must be at least 1");
    end
    if (N_CHANNEL < 2) begin : gChannelCheck
        $error("tri_bus_arbiter: N_CHANNEL must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, TURN, EXT} arbState_e;

    arbState_e            state, stateNext;
    logic [IW-1:0]        owner, ownerNext;
    logic [IW-1:0]        ptr, ptrNext;
    logic [BW-1:0]        burst, burstNext;
    logic [TW-1:0]        turn, turnNext;
    logic [N_CHANNEL-1:0] gnt, gntNext;
    logic                 oe;
    logic                 extGnt;
    logic [WIDTH-1:0]     rdData;
    logic                 rdValid;
    logic [WIDTH-1:0]     ownerData;
    logic                 rrFound;
    logic [IW-1:0]        rrIdx;
    logic [IW-1:0]        rrCand;
    logic                 arbitrate;
    logic                 burstLimit;

    always_comb begin
        ownerData = '0;
        for (int k = 0; k < N_CHANNEL; k++) begin
            if (owner == IW'(k)) ownerData = bus.i_data[k*WIDTH +: WIDTH];
        end
    end

    assign b_bus = oe ? ownerData : {WIDTH{1'bz}};

    // Search starts one past the last winner, so a just-expired owner is considered last.
    always_comb begin
        rrFound = 1'b0;
        rrIdx   = ptr;
        rrCand  = '0;
        for (int i = 1; i <= N_CHANNEL; i++) begin
            rrCand = IW'((int'(ptr) + i) % N_CHANNEL);
            if (!rrFound && bus.i_req[rrCand]) begin
                rrFound = 1'b1;
                rrIdx   = rrCand;
            end
        end
    end

    assign burstLimit = (MAX_BURST != 0) && (burst >= BURST_LIM);

    always_comb begin
        stateNext = state;
        ownerNext = owner;
        ptrNext   = ptr;
        burstNext = burst;
        turnNext  = turn;
        arbitrate = 1'b0;
        case (state)
            IDLE: arbitrate = 1'b1;
            DRIVE: begin
                if (bus.i_req[owner] && !bus.i_extReq && !burstLimit) begin
                    if (burst != '1) burstNext = burst + BW'(1);
                end else begin
                    stateNext = TURN;
                    turnNext  = TURN_INIT;
                end
            end
            TURN: begin
                // Final gap cycle doubles as the idle decision, keeping release-to-grant at TURN_CYCLES+1.
                if (turn <= TW'(1)) arbitrate = 1'b1;
                else turnNext = turn - TW'(1);
            end
            EXT: begin
                if (!bus.i_extReq) begin
                    stateNext = TURN;
                    turnNext  = TURN_INIT;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (arbitrate) begin
            stateNext = IDLE;
            if (bus.i_extReq) begin
                stateNext = EXT;
            end else if (rrFound) begin
                stateNext = DRIVE;
                ownerNext = rrIdx;
                ptrNext   = rrIdx;
                burstNext = BW'(1);
            end
        end

        gntNext = '0;
        for (int k = 0; k < N_CHANNEL; k++) begin
            gntNext[k] = (stateNext == DRIVE) && (ownerNext == IW'(k));
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= IW'(N_CHANNEL - 1);
            burst   <= '0;
            turn    <= '0;
            gnt     <= '0;
            oe      <= 1'b0;
            extGnt  <= 1'b0;
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            state   <= stateNext;
            owner   <= ownerNext;
            ptr     <= ptrNext;
            burst   <= burstNext;
            turn    <= turnNext;
            gnt     <= gntNext;
            oe      <= (stateNext == DRIVE);
            extGnt  <= (stateNext == EXT);
            rdData  <= b_bus;
            rdValid <= extGnt;
        end
    end

    assign bus.o_gnt     = gnt;
    assign bus.o_oe      = oe;
    assign bus.o_extGnt  = extGnt;
    assign bus.o_rdData  = rdData;
    assign bus.o_rdValid = rdValid;

`ifdef TRI_BUS_ARBITER_CONTENTION_CHECK_EN
    logic contention;

    // A set in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            contention <= 1'b0;
        end else if (oe && (b_bus !== ownerData)) begin
            contention <= 1'b1;
        end else if (bus.i_clrContention) begin
            contention <= 1'b0;
        end
    end

    assign bus.o_contention = contention;
`else
    logic unusedClr;

    assign unusedClr        = bus.i_clrContention;
    assign bus.o_contention = 1'b0;
`endif
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: vector table, hand-written corner sequences and a randomized run
// against an owner/gap model of the arbitration rules.
module tb_tri_bus_arbiter;
    localparam int W      = 8;
    localparam int N      = 4;
    localparam int TC_A   = 1;
    localparam int MB_A   = 2;
    localparam int EXT_ID = N;
    localparam int FREE   = -1;

    typedef struct {
        logic [N-1:0] req;
        logic         ext;
        logic [N-1:0] gnt;
        logic         oe;
        logic         extGnt;
    } vec_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    tri_bus_arbiter_if #(.WIDTH(W), .N_CHANNEL(N)) ifA();
    tri_bus_arbiter_if #(.WIDTH(W), .N_CHANNEL(N)) ifB();
    tri [W-1:0] busA;
    tri [W-1:0] busB;
    logic         extDrv;
    logic [W-1:0] extData;

    assign busA = extDrv ? extData : {W{1'bz}};

    tri_bus_arbiter #(.WIDTH(W), .N_CHANNEL(N), .TURN_CYCLES(TC_A), .MAX_BURST(MB_A)) dutA (
        .i_clk(clk), .i_arst_n(rstN), .bus(ifA.slave), .b_bus(busA));
    tri_bus_arbiter #(.WIDTH(W), .N_CHANNEL(N), .TURN_CYCLES(1), .MAX_BURST(0)) dutB (
        .i_clk(clk), .i_arst_n(rstN), .bus(ifB.slave), .b_bus(busB));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t         tbl[17];
    logic [N-1:0] req;
    logic         ext;
    logic [31:0]  dataA;
    logic [W-1:0] busNow;
    logic         busKnown;
    logic         wasExt;
    logic [N-1:0] expGnt;
    logic [W-1:0] expData;
    int           mOwner, mQuiet, mUsed, mLast;
    bit           picked;

    initial begin
        // Round robin on 1011 with 2-cycle bursts and 1-cycle gaps, then an external takeover.
        tbl[0]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[1]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[2]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'b1011, 1'b0, 4'b0010, 1'b1, 1'b0};
        tbl[4]  = '{4'b1011, 1'b0, 4'b0010, 1'b1, 1'b0};
        tbl[5]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b1011, 1'b0, 4'b1000, 1'b1, 1'b0};
        tbl[7]  = '{4'b1011, 1'b0, 4'b1000, 1'b1, 1'b0};
        tbl[8]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[10] = '{4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[12] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

        extDrv = 1'b0;
        extData = '0;
        dataA = {8'h44, 8'h33, 8'h22, 8'h11};
        ifA.i_req = 4'b0001;
        ifA.i_data = dataA;
        ifA.i_extReq = 1'b0;
        ifA.i_clrContention = 1'b0;
        ifB.i_req = '0;
        ifB.i_data = {8'h5A, 8'h6B, 8'h3C, 8'h7D};
        ifB.i_extReq = 1'b0;
        ifB.i_clrContention = 1'b0;
        tick();
        tick();

        // Reset and asynchronous reset mid-burst
        check("rstGnt", ifA.o_gnt, 4'b0000);
        check("rstOe", ifA.o_oe, 1'b0);
        rstN = 1'b1;
        tick();
        check("firstGnt", ifA.o_gnt, 4'b0001);
        check("firstOe", ifA.o_oe, 1'b1);
        check("firstBus", busA, 8'h11);
        tick();
        check("midBurstRd", ifA.o_rdData, 8'h11);
        #3;
        rstN = 1'b0;
        #1;
        check("asyncOe", ifA.o_oe, 1'b0);
        check("asyncGnt", ifA.o_gnt, 4'b0000);
        check("asyncExtGnt", ifA.o_extGnt, 1'b0);
        check("asyncRdData", ifA.o_rdData, 8'h00);
        check("asyncRdValid", ifA.o_rdValid, 1'b0);
        check("asyncContention", ifA.o_contention, 1'b0);
        ifA.i_req = '0;
        tick();
        rstN = 1'b1;

        for (int v = 0; v < 17; v++) begin
            ifA.i_req = tbl[v].req;
            ifA.i_extReq = tbl[v].ext;
            tick();
            check($sformatf("vec%0d.gnt", v), ifA.o_gnt, tbl[v].gnt);
            check($sformatf("vec%0d.oe", v), ifA.o_oe, tbl[v].oe);
            check($sformatf("vec%0d.extGnt", v), ifA.o_extGnt, tbl[v].extGnt);
            if (tbl[v].oe) begin
                expData = '0;
                for (int k = 0; k < N; k++) if (tbl[v].gnt[k]) expData = dataA[k*W +: W];
                check($sformatf("vec%0d.bus", v), busA, expData);
            end
        end

        // External request beats a simultaneous internal one from IDLE; read path during EXT
        ifA.i_req = 4'b0100;
        ifA.i_extReq = 1'b1;
        tick();
        check("prioExtGnt", ifA.o_extGnt, 1'b1);
        check("prioGnt", ifA.o_gnt, 4'b0000);
        check("prioRdValidLate", ifA.o_rdValid, 1'b0);
        extDrv = 1'b1;
        extData = 8'hA5;
        tick();
        check("readData", ifA.o_rdData, 8'hA5);
        check("readValid", ifA.o_rdValid, 1'b1);
        check("prioGntHeld", ifA.o_gnt, 4'b0000);
        ifA.i_extReq = 1'b0;
        extDrv = 1'b0;
        tick();
        check("extDropGnt", ifA.o_extGnt, 1'b0);
        check("extDropNoGnt", ifA.o_gnt, 4'b0000);
        tick();
        check("afterExtGnt", ifA.o_gnt, 4'b0100);
        check("afterExtBus", busA, 8'h33);
        ifA.i_req = '0;
        tick();
        tick();

        // Unlimited burst on the second instance
        ifB.i_req = 4'b0010;
        tick();
        check("burstGnt", ifB.o_gnt, 4'b0010);
        for (int c = 0; c < 40; c++) begin
            tick();
            check($sformatf("burstHold%0d", c), {ifB.o_oe, ifB.o_gnt, busB}, {1'b1, 4'b0010, 8'h3C});
        end
        ifB.i_req = '0;
        tick();
        check("burstReleaseOe", ifB.o_oe, 1'b0);

`ifdef TRI_BUS_ARBITER_CONTENTION_CHECK_EN
        ifA.i_data = {8'h44, 8'h33, 8'h22, 8'hFF};
        ifA.i_req = 4'b0001;
        tick();
        extDrv = 1'b1;
        extData = 8'h00;
        tick();
        extDrv = 1'b0;
        ifA.i_req = '0;
        check("contentionSet", ifA.o_contention, 1'b1);
        tick();
        tick();
        tick();
        check("contentionSticky", ifA.o_contention, 1'b1);
        ifA.i_clrContention = 1'b1;
        tick();
        ifA.i_clrContention = 1'b0;
        check("contentionClear", ifA.o_contention, 1'b0);
`else
        ifA.i_clrContention = 1'b1;
        tick();
        ifA.i_clrContention = 1'b0;
        check("contentionTied", ifA.o_contention, 1'b0);
`endif

        // Randomized run against the owner/gap model
        rstN = 1'b0;
        ifA.i_req = '0;
        ifA.i_extReq = 1'b0;
        extDrv = 1'b0;
        tick();
        rstN = 1'b1;
        req = '0;
        ext = 1'b0;
        mOwner = FREE;
        mQuiet = 0;
        mUsed = 0;
        mLast = N - 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) ext = ~ext;
            dataA = $urandom;
            ifA.i_req = req;
            ifA.i_extReq = ext;
            ifA.i_data = dataA;
            ifA.i_clrContention = 1'($urandom_range(0, 1));
            extDrv = (mOwner == EXT_ID);
            extData = 8'($urandom_range(0, 255));

            busKnown = 1'b1;
            busNow = '0;
            if (mOwner == EXT_ID) busNow = extData;
            else if (mOwner == FREE) busKnown = 1'b0;
            else for (int k = 0; k < N; k++) if (k == mOwner) busNow = dataA[k*W +: W];
            wasExt = (mOwner == EXT_ID);
            #1;
            if (mOwner >= 0 && mOwner < N) check("rndBus", busA, busNow);

            if (mOwner == EXT_ID) begin
                if (!ext) begin
                    mOwner = FREE;
                    mQuiet = TC_A;
                end
            end else if (mOwner != FREE) begin
                if (req[mOwner] && !ext && (MB_A == 0 || mUsed < MB_A)) begin
                    mUsed++;
                end else begin
                    mOwner = FREE;
                    mQuiet = TC_A;
                end
            end else if (mQuiet > 1) begin
                mQuiet--;
            end else begin
                mQuiet = 0;
                if (ext) begin
                    mOwner = EXT_ID;
                end else begin
                    picked = 1'b0;
                    for (int i = 1; i <= N; i++) begin
                        if (!picked && req[(mLast + i) % N]) begin
                            picked = 1'b1;
                            mOwner = (mLast + i) % N;
                        end
                    end
                    if (picked) begin
                        mLast = mOwner;
                        mUsed = 1;
                    end
                end
            end

            @(posedge clk);
            #1;
            expGnt = '0;
            for (int k = 0; k < N; k++) if (k == mOwner) expGnt[k] = 1'b1;
            check("rndGnt", ifA.o_gnt, expGnt);
            check("rndOe", ifA.o_oe, (mOwner >= 0 && mOwner < N));
            check("rndExtGnt", ifA.o_extGnt, (mOwner == EXT_ID));
            check("rndRdValid", ifA.o_rdValid, wasExt);
            check("rndContention", ifA.o_contention, 1'b0);
            if (busKnown) check("rndRdData", ifA.o_rdData, busNow);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
